// File: rtl/event_dispatcher_pkg.sv
// Shared defaults and unit state encoding for the event dispatcher.
// Imported by the dispatcher top and its per-unit slots.
package event_dispatcher_pkg;

    localparam int DEF_N_UNITS = 4;
    localparam int DEF_PTR_W   = $clog2(DEF_N_UNITS);
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TO_W    = 10;
    localparam int DEF_TIMEOUT = 1000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } unit_state_t;

endpackage

// File: rtl/dispatch_slot.sv
// One downstream unit: busy state, watchdog counter and sticky timeout flag.
// timeout pulses on the last allowed busy cycle, even if done arrives with it.
module dispatch_slot
    import event_dispatcher_pkg::*;
#(
    parameter int TO_W    = DEF_TO_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic launch,
    input  logic done,
    input  logic clear,
    output logic busy,
    output logic timeout,
    output logic flag
);

    unit_state_t     state;
    logic [TO_W-1:0] cnt;

    assign busy    = (state == BUSY);
    assign timeout = busy && (cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            if (launch) begin
                state <= BUSY;
                cnt   <= '0;
            end else if (busy && (done || timeout)) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (busy) begin
                cnt <= cnt + TO_W'(1);
            end
            // a done arriving with the timeout counts as a normal completion
            if (clear)
                flag <= 1'b0;
            else if (timeout && !done)
                flag <= 1'b1;
        end
    end

endmodule

// File: rtl/event_dispatcher.sv
// Round-robin dispatcher sharing N units among a stream of event pulses.
// Busy units are skipped; events with no idle unit are counted as drops.
module event_dispatcher
    import event_dispatcher_pkg::*;
#(
    parameter int N_UNITS = DEF_N_UNITS,
    parameter int PTR_W   = DEF_PTR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TO_W    = DEF_TO_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               stat_clear,
    input  logic               in,
    input  logic [N_UNITS-1:0] unit_done,
    output logic [N_UNITS-1:0] dispatch,
    output logic [N_UNITS-1:0] unit_busy,
    output logic               all_busy,
    output logic [PTR_W-1:0]   next_unit,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [N_UNITS-1:0] timeout_flag
);

    logic [N_UNITS-1:0] grant;
    logic [N_UNITS-1:0] expire;
    logic [N_UNITS-1:0] freed;
    logic [N_UNITS-1:0] busy_d;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   idx;
    logic               found;
    logic               accept;
    logic               drop;

    for (genvar g = 0; g < N_UNITS; g++) begin : g_slot
        dispatch_slot #(
            .TO_W    (TO_W),
            .TIMEOUT (TIMEOUT)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .launch  (grant[g]),
            .done    (unit_done[g]),
            .clear   (stat_clear),
            .busy    (unit_busy[g]),
            .timeout (expire[g]),
            .flag    (timeout_flag[g])
        );
    end

    // scan from the pointer using registered busy, so a unit freed
    // this cycle only becomes eligible next cycle
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            idx = PTR_W'((int'(next_unit) + k) % N_UNITS);
            if (!found && !unit_busy[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        accept = in && enable;
        drop   = accept && !found;
        grant  = '0;
        if (accept && found)
            grant[sel] = 1'b1;
    end

    assign freed  = unit_busy & (unit_done | expire);
    assign busy_d = (unit_busy & ~freed) | grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dispatch  <= '0;
            all_busy  <= 1'b0;
            next_unit <= '0;
            drop_cnt  <= '0;
        end else begin
            dispatch <= grant;
            all_busy <= &busy_d;
            if (accept && found)
                next_unit <= (sel == PTR_W'(N_UNITS - 1)) ? '0 : sel + 1'b1;
            if (stat_clear)
                drop_cnt <= '0;
            else if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_event_dispatcher.sv
// Self-checking bench for event_dispatcher: vector table, directed corners,
// and random traffic against a busy-cycles-remaining reference model.
module tb_event_dispatcher;

    localparam int N    = 4;
    localparam int TMO  = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          stat_clear;
    logic          ev;
    logic [N-1:0]  unit_done;
    logic [N-1:0]  dispatch;
    logic [N-1:0]  unit_busy;
    logic          all_busy;
    logic [1:0]    next_unit;
    logic [CW-1:0] drop_cnt;
    logic [N-1:0]  timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;

    bit       m_busy[N];
    int       m_left[N];
    bit [N-1:0] m_flag;
    bit [N-1:0] m_disp;
    int       m_ptr;
    int       m_cnt;

    typedef struct {
        logic          ev;
        logic [N-1:0]  done;
        logic [N-1:0]  disp;
        logic [N-1:0]  busy;
        logic [1:0]    ptr;
        logic [CW-1:0] drops;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    event_dispatcher #(
        .N_UNITS (N),
        .PTR_W   (2),
        .CNT_W   (CW),
        .TO_W    (10),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .stat_clear   (stat_clear),
        .in           (ev),
        .unit_done    (unit_done),
        .dispatch     (dispatch),
        .unit_busy    (unit_busy),
        .all_busy     (all_busy),
        .next_unit    (next_unit),
        .drop_cnt     (drop_cnt),
        .timeout_flag (timeout_flag)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < N; u++) begin
            m_busy[u] = 1'b0;
            m_left[u] = 0;
        end
        m_flag = '0;
        m_disp = '0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // each launch grants a unit TMO busy cycles unless done ends it early
    task automatic model_step();
        int sel;
        bit [N-1:0] hit;
        sel = -1;
        hit = '0;
        if (ev && enable) begin
            for (int k = 0; k < N; k++) begin
                int uu;
                uu = (m_ptr + k) % N;
                if (sel < 0 && !m_busy[uu])
                    sel = uu;
            end
        end
        for (int u = 0; u < N; u++) begin
            if (m_busy[u]) begin
                if (unit_done[u]) begin
                    m_busy[u] = 1'b0;
                end else if (m_left[u] == 1) begin
                    m_busy[u] = 1'b0;
                    hit[u] = 1'b1;
                end else begin
                    m_left[u]--;
                end
            end
        end
        m_disp = '0;
        if (sel >= 0) begin
            m_busy[sel] = 1'b1;
            m_left[sel] = TMO;
            m_disp[sel] = 1'b1;
            m_ptr = (sel + 1) % N;
        end else if (ev && enable && m_cnt < CMAX) begin
            m_cnt++;
        end
        if (stat_clear) begin
            m_cnt  = 0;
            m_flag = '0;
        end else begin
            m_flag |= hit;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eb;
        for (int u = 0; u < N; u++)
            eb[u] = m_busy[u];
        check("dispatch", 32'(dispatch), 32'(m_disp));
        check("unit_busy", 32'(unit_busy), 32'(eb));
        check("all_busy", 32'(all_busy), 32'(&eb));
        check("next_unit", 32'(next_unit), 32'(m_ptr));
        check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
        check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
    endtask

    task automatic drive(logic e, logic en, logic clr, logic [N-1:0] d);
        ev         = e;
        enable     = en;
        stat_clear = clr;
        unit_done  = d;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, '0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'b0000, 4'b0001, 4'b0001, 2'd1, 4'd0};
        tbl[1] = '{1'b1, 4'b0000, 4'b0010, 4'b0011, 2'd2, 4'd0};
        tbl[2] = '{1'b1, 4'b0000, 4'b0100, 4'b0111, 2'd3, 4'd0};
        tbl[3] = '{1'b1, 4'b0000, 4'b1000, 4'b1111, 2'd0, 4'd0};
        tbl[4] = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 4'd1};
        tbl[5] = '{1'b0, 4'b0100, 4'b0000, 4'b1011, 2'd0, 4'd1};
        tbl[6] = '{1'b1, 4'b0000, 4'b0100, 4'b1111, 2'd3, 4'd1};
        tbl[7] = '{1'b1, 4'b0010, 4'b0000, 4'b1101, 2'd3, 4'd2};
        tbl[8] = '{1'b1, 4'b0000, 4'b0010, 4'b1111, 2'd2, 4'd2};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // basic fill, drop, release and done-vs-select ordering
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ev, 1'b1, 1'b0, tbl[i].done);
            step();
            check($sformatf("tbl%0d.disp", i), 32'(dispatch), 32'(tbl[i].disp));
            check($sformatf("tbl%0d.busy", i), 32'(unit_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d.ptr", i), 32'(next_unit), 32'(tbl[i].ptr));
            check($sformatf("tbl%0d.drops", i), 32'(drop_cnt), 32'(tbl[i].drops));
            if (i == 3)
                check("tbl3.all_busy", 32'(all_busy), 32'd1);
        end

        // timeout release, sticky flag, clear, done coinciding with timeout
        do_reset();
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        drive(1'b0, 1'b1, 1'b0, '0);
        repeat (TMO - 1) step();
        check("to.still_busy", 32'(unit_busy[0]), 32'd1);
        step();
        check("to.released", 32'(unit_busy[0]), 32'd0);
        check("to.flag", 32'(timeout_flag), 32'b0001);
        repeat (3) step();
        check("to.flag_sticky", 32'(timeout_flag), 32'b0001);
        drive(1'b0, 1'b1, 1'b1, '0);
        step();
        check("to.flag_cleared", 32'(timeout_flag), 32'b0000);
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        check("to.disp_u1", 32'(dispatch), 32'b0010);
        drive(1'b0, 1'b1, 1'b0, '0);
        repeat (TMO - 1) step();
        drive(1'b0, 1'b1, 1'b0, 4'b0010);
        step();
        check("to.done_wins_busy", 32'(unit_busy[1]), 32'd0);
        check("to.done_wins_flag", 32'(timeout_flag), 32'b0000);

        // drop counter saturation, then clear coincident with a drop
        do_reset();
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (80) step();
        check("sat.drop_cnt", 32'(drop_cnt), 32'(CMAX));
        drive(1'b1, 1'b1, 1'b1, '0);
        step();
        check("sat.clear", 32'(drop_cnt), 32'd0);

        // disabled input neither dispatches nor drops
        do_reset();
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("dis.dispatch", 32'(dispatch), 32'd0);
            check("dis.drop_cnt", 32'(drop_cnt), 32'd0);
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        drive(1'b1, 1'b1, 1'b0, '0);
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset.busy", 32'(unit_busy), 32'd0);
        check("areset.dispatch", 32'(dispatch), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        check("areset.release_disp", 32'(dispatch), 32'd0);
        step();
        check("areset.first", 32'(dispatch), 32'b0001);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] d;
            for (int u = 0; u < N; u++)
                d[u] = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 31) == 0), d);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/event_dispatcher.md
Name: event_dispatcher

Overview:
- Round-robin scheduler that shares N downstream processing units among one stream of single-cycle event pulses.
- Generalises two-way A/B alternation to N units, and skips units that are still busy.
- Sits between the trigger/hit-pulse source and the per-unit readout/processing engines.
- Tracks per-unit busy via a launch/done handshake, counts dropped events, and recovers hung units by timeout.

Parameters:
- N_UNITS, 4: number of downstream units (2..16).
- PTR_W, 2: pointer width, equal to clog2(N_UNITS).
- CNT_W, 16: drop counter width.
- TO_W, 10: timeout counter width.
- TIMEOUT, 1000: busy cycles before a unit is force-released (1..2^TO_W-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  accept events when 1.
- stat_clear  in  1  synchronous clear of drop_cnt and timeout_flag.
- in  in  1  event request pulse; each high cycle is one event.
- unit_done  in  N_UNITS  per-unit completion pulse.
- dispatch  out  N_UNITS  one-hot launch pulse, registered.
- unit_busy  out  N_UNITS  registered busy state per unit.
- all_busy  out  1  registered; equals the AND of unit_busy.
- next_unit  out  PTR_W  round-robin start pointer.
- drop_cnt  out  CNT_W  saturating count of dropped events.
- timeout_flag  out  N_UNITS  sticky per-unit timeout indicator.

Behaviour:
- Reset (async, active-high): every output and all internal state go to 0; the pointer goes to 0.
- Per-unit state: IDLE or BUSY.
  - IDLE->BUSY when dispatched.
  - BUSY->IDLE on unit_done, or when the timeout counter reaches TIMEOUT.
  - unit_done on an IDLE unit is ignored.
- Selection in cycle t uses registered unit_busy from cycle t, before that cycle's done/timeout updates.
  - A unit released in cycle t is first eligible in cycle t+1.
- Event accepted in cycle t when in=1 and enable=1:
  - Pick the first IDLE unit scanning next_unit, next_unit+1, ... with modulo N_UNITS wrap.
  - dispatch[sel]=1 for exactly cycle t+1; unit_busy[sel]=1 from t+1.
  - next_unit becomes (sel+1) mod N_UNITS at t+1.
- Latency: fixed 1 cycle from in to dispatch. Back-to-back events on consecutive cycles each dispatch to a distinct unit.
- All units busy in cycle t with an accepted event:
  - No dispatch; pointer unchanged.
  - drop_cnt increments at t+1 and saturates at 2^CNT_W-1 with no wrap.
- enable=0: events are ignored and not counted as drops. Done and timeout processing continue.
- Timeout:
  - Per-unit counter clears on dispatch and increments each BUSY cycle.
  - On reaching TIMEOUT: unit goes IDLE next cycle, timeout_flag[u] sets and stays set, counter clears.
  - If unit_done and timeout hit in the same cycle, done wins and the flag does not set.
- stat_clear:
  - Zeroes drop_cnt and timeout_flag next cycle.
  - It has priority over a simultaneous drop or timeout in the same cycle: result is 0 and that event is not recorded.
  - Busy state and pointer are unaffected.
- Reset mid-operation: in-flight units are forgotten (busy=0) and no dispatch pulse is emitted while reset is high or on the cycle it is released.

Decomposition:
- Package event_dispatcher_pkg: default N_UNITS, CNT_W, TO_W, TIMEOUT constants, and a unit-state enum (IDLE/BUSY).
- Sub-module dispatch_slot, instantiated N_UNITS times:
  - Holds the busy flop, timeout counter and sticky timeout flag.
  - Inputs: launch, done, clear. Outputs: busy, timeout pulse.
- Round-robin picker, pointer and drop counter stay in the top level.

Test Plan:
- N_UNITS=4, no done, in pulses at cycles 10,11,12,13 -> dispatch=0001,0010,0100,1000 at cycles 11..14; all_busy=1 at 14; next_unit=0.
- Fifth pulse at 14 with all busy -> no dispatch; drop_cnt=1 at 15. Then unit_done=0100 at 20 and in at 21 -> dispatch=0100 at 22, next_unit=3.
- unit_done[1] and in in the same cycle, unit 1 being the only IDLE candidate per pointer order -> unit 1 not selected that cycle; event drops if others busy, and the following event takes unit 1.
- TIMEOUT=5, dispatch unit 0 and never send done -> unit_busy[0] clears 5 busy cycles later; timeout_flag=0001 until stat_clear; a done in the same cycle as the timeout leaves the flag at 0.
- CNT_W=4, 20 drops -> drop_cnt=15 (saturated). stat_clear coincident with a drop -> 0. enable=0 with in pulses -> no dispatch, no drop.
- Assert reset asynchronously mid-burst with 3 units busy -> outputs 0 immediately; first event after release -> dispatch=0001.
